// File: rtl/ortho_burst_ctrl_pkg.sv
// Shared definitions for the ultrasound transmit burst sequencer.
package ortho_burst_ctrl_pkg;

    // Sequencer state encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TX     = 2'd1,
        ST_LISTEN = 2'd2
    } state_t;

    // Default field widths
    localparam int DEF_DIV_W = 18;
    localparam int DEF_CYC_W = 8;
    localparam int DEF_LIS_W = 20;
    localparam int DEF_BST_W = 8;

    // Smallest usable half-period; anything below is raised to this
    localparam int HALF_MIN = 2;

endpackage

// File: rtl/ortho_burst_ctrl_if.sv
// Host/config side and drive-pin side of the burst sequencer.
interface ortho_burst_ctrl_if #(
    parameter int DIV_W = ortho_burst_ctrl_pkg::DEF_DIV_W,
    parameter int CYC_W = ortho_burst_ctrl_pkg::DEF_CYC_W,
    parameter int LIS_W = ortho_burst_ctrl_pkg::DEF_LIS_W,
    parameter int BST_W = ortho_burst_ctrl_pkg::DEF_BST_W
) ();
    logic             start;
    logic             abort;
    logic [DIV_W-1:0] cfg_half;
    logic [CYC_W-1:0] cfg_cycles;
    logic [LIS_W-1:0] cfg_listen;
    logic [BST_W-1:0] cfg_bursts;
    logic             sq_0deg;
    logic             sq_90deg;
    logic             rx_win;
    logic             busy;
    logic             done;
    logic [BST_W-1:0] burst_idx;

    modport master (
        output start, abort, cfg_half, cfg_cycles, cfg_listen, cfg_bursts,
        input  sq_0deg, sq_90deg, rx_win, busy, done, burst_idx
    );

    modport slave (
        input  start, abort, cfg_half, cfg_cycles, cfg_listen, cfg_bursts,
        output sq_0deg, sq_90deg, rx_win, busy, done, burst_idx
    );
endinterface

// File: rtl/ortho_burst_ctrl_square_rt.sv
// Programmable quadrature square-wave core. While en is high the counter
// runs 0..half-1; the 90 deg output toggles mid half-period, the 0 deg
// output at the wrap. fall_tick is a combinational strobe marking the
// clock edge on which sq_0deg goes 1->0, so the caller can react on that
// very edge. half must already be clamped to >= 2.
module ortho_square_rt #(
    parameter int DIV_W = ortho_burst_ctrl_pkg::DEF_DIV_W
) (
    input  logic             clk_50M,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] half,
    output logic             sq_0deg,
    output logic             sq_90deg,
    output logic             fall_tick
);
    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] q_pt;
    logic [DIV_W-1:0] end_pt;
    logic             at_q;
    logic             at_end;

    assign q_pt      = (half >> 1) - ONE;
    assign end_pt    = half - ONE;
    assign at_q      = (cnt == q_pt);
    assign at_end    = (cnt == end_pt);
    assign fall_tick = en && at_end && sq_0deg;

    // Half-period counter and the two phase-shifted toggles
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            sq_0deg  <= 1'b0;
            sq_90deg <= 1'b0;
        end else if (!en) begin
            cnt      <= '0;
            sq_0deg  <= 1'b0;
            sq_90deg <= 1'b0;
        end else begin
            cnt <= at_end ? '0 : cnt + ONE;
            if (at_q)
                sq_90deg <= ~sq_90deg;
            if (at_end)
                sq_0deg <= ~sq_0deg;
        end
    end
endmodule

// File: rtl/ortho_burst_ctrl.sv
// Transmit burst sequencer: N quadrature periods, then an L-clock listen
// window, repeated B times. Config is captured on start so the host can
// rewrite registers while a sequence runs.
module ortho_burst_ctrl #(
    parameter int DIV_W = ortho_burst_ctrl_pkg::DEF_DIV_W,
    parameter int CYC_W = ortho_burst_ctrl_pkg::DEF_CYC_W,
    parameter int LIS_W = ortho_burst_ctrl_pkg::DEF_LIS_W,
    parameter int BST_W = ortho_burst_ctrl_pkg::DEF_BST_W
) (
    input logic                clk_50M,
    input logic                rst,
    ortho_burst_ctrl_if.slave  bus
);
    import ortho_burst_ctrl_pkg::*;

    localparam logic [DIV_W-1:0] HMIN  = DIV_W'(HALF_MIN);
    localparam logic [CYC_W-1:0] ONE_C = CYC_W'(1);
    localparam logic [LIS_W-1:0] ONE_L = LIS_W'(1);
    localparam logic [BST_W-1:0] ONE_B = BST_W'(1);

    state_t           state;
    logic [DIV_W-1:0] h_sh;
    logic [CYC_W-1:0] n_sh;
    logic [LIS_W-1:0] l_sh;
    logic [BST_W-1:0] b_last;     // effective burst count minus one
    logic [CYC_W-1:0] pcnt;
    logic [LIS_W-1:0] lcnt;
    logic [BST_W-1:0] idx;
    logic             rx_q;
    logic             busy_q;
    logic             done_q;

    logic tx_en;
    logic fall_tick;
    logic sq0;
    logic sq90;
    logic period_last;
    logic listen_last;
    logic more_bursts;

    // Abort gates the core on the same edge the FSM leaves TX
    assign tx_en       = (state == ST_TX) && !bus.abort;
    assign period_last = (pcnt == n_sh - ONE_C);
    assign listen_last = (lcnt == l_sh - ONE_L);
    assign more_bursts = (idx < b_last);

    ortho_square_rt #(.DIV_W(DIV_W)) u_sq (
        .clk_50M   (clk_50M),
        .rst       (rst),
        .en        (tx_en),
        .half      (h_sh),
        .sq_0deg   (sq0),
        .sq_90deg  (sq90),
        .fall_tick (fall_tick)
    );

    assign bus.sq_0deg   = sq0;
    assign bus.sq_90deg  = sq90;
    assign bus.rx_win    = rx_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.burst_idx = idx;

    // Sequencer FSM with shadow config and period/listen/burst counters.
    // burst_idx returns to 0 whenever the sequencer goes back to IDLE.
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            h_sh   <= HMIN;
            n_sh   <= '0;
            l_sh   <= '0;
            b_last <= '0;
            pcnt   <= '0;
            lcnt   <= '0;
            idx    <= '0;
            rx_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.abort) begin
                state  <= ST_IDLE;
                pcnt   <= '0;
                lcnt   <= '0;
                idx    <= '0;
                rx_q   <= 1'b0;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.start) begin
                            h_sh   <= (bus.cfg_half < HMIN) ? HMIN : bus.cfg_half;
                            n_sh   <= bus.cfg_cycles;
                            l_sh   <= bus.cfg_listen;
                            b_last <= (bus.cfg_bursts == '0) ? '0 : bus.cfg_bursts - ONE_B;
                            pcnt   <= '0;
                            lcnt   <= '0;
                            idx    <= '0;
                            if (bus.cfg_cycles != '0) begin
                                state  <= ST_TX;
                                busy_q <= 1'b1;
                            end else if (bus.cfg_listen != '0) begin
                                state  <= ST_LISTEN;
                                busy_q <= 1'b1;
                                rx_q   <= 1'b1;
                            end else begin
                                // Nothing to transmit or hear: complete at once
                                done_q <= 1'b1;
                            end
                        end
                    end
                    ST_TX: begin
                        if (fall_tick) begin
                            if (period_last) begin
                                pcnt <= '0;
                                if (l_sh != '0) begin
                                    state <= ST_LISTEN;
                                    rx_q  <= 1'b1;
                                    lcnt  <= '0;
                                end else if (more_bursts) begin
                                    // Core has just wrapped to cnt=0, so staying in TX restarts it
                                    idx <= idx + ONE_B;
                                end else begin
                                    state  <= ST_IDLE;
                                    busy_q <= 1'b0;
                                    done_q <= 1'b1;
                                    idx    <= '0;
                                end
                            end else begin
                                pcnt <= pcnt + ONE_C;
                            end
                        end
                    end
                    ST_LISTEN: begin
                        if (listen_last) begin
                            lcnt <= '0;
                            if (more_bursts) begin
                                idx <= idx + ONE_B;
                                // With N=0 the next burst is just another listen window
                                if (n_sh != '0) begin
                                    state <= ST_TX;
                                    rx_q  <= 1'b0;
                                end
                            end else begin
                                state  <= ST_IDLE;
                                rx_q   <= 1'b0;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                                idx    <= '0;
                            end
                        end else begin
                            lcnt <= lcnt + ONE_L;
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        rx_q   <= 1'b0;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ortho_burst_ctrl.sv
// Bench for ortho_burst_ctrl: an expected-waveform model plus directed
// literal traces and a randomized soak.
module tb_ortho_burst_ctrl;

    typedef struct packed {
        logic       sq0;
        logic       sq90;
        logic       rx;
        logic       busy;
        logic       done;
        logic [7:0] idx;
    } out_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    ortho_burst_ctrl_if bus ();

    ortho_burst_ctrl dut (
        .clk_50M (clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #10 clk = ~clk;

    // ---------------- reference model ----------------
    // On an accepted start the whole expected output waveform is laid out
    // in a queue, one entry per clock after the start edge.
    out_t q[$];
    out_t exp_o = '0;

    task automatic build(input int hc, input int n, input int l, input int b);
        int   h;
        int   bb;
        out_t e;
        h  = (hc < 2) ? 2 : hc;
        bb = (b == 0) ? 1 : b;
        q.delete();
        if (n != 0 || l != 0) begin
            for (int bi = 0; bi < bb; bi++) begin
                for (int t = 0; t < 2 * h * n; t++) begin
                    e      = '0;
                    e.sq0  = ((t / h) % 2) == 1;
                    e.sq90 = (t >= h / 2) && (((t - h / 2) / h) % 2 == 0);
                    e.busy = 1'b1;
                    e.idx  = 8'(bi);
                    q.push_back(e);
                end
                for (int t = 0; t < l; t++) begin
                    e      = '0;
                    e.rx   = 1'b1;
                    e.busy = 1'b1;
                    e.idx  = 8'(bi);
                    q.push_back(e);
                end
            end
        end
        e      = '0;
        e.done = 1'b1;
        q.push_back(e);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            exp_o = '0;
        end else if (bus.abort) begin
            q.delete();
            exp_o = '0;
        end else begin
            if (!exp_o.busy && bus.start)
                build(int'(bus.cfg_half), int'(bus.cfg_cycles), int'(bus.cfg_listen), int'(bus.cfg_bursts));
            if (q.size() > 0)
                exp_o = q.pop_front();
            else
                exp_o = '0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s t=%0t got %h want %h", name, $time, act, want);
        end
    endtask

    function automatic out_t dut_out();
        return {bus.sq_0deg, bus.sq_90deg, bus.rx_win, bus.busy, bus.done, bus.burst_idx};
    endfunction

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        check("cycle", 32'(dut_out()), 32'(exp_o));
    end

    // ---------------- directed trace capture ----------------
    logic [63:0] tr_sq0, tr_sq90, tr_rx, tr_busy, tr_done;
    logic [7:0]  tr_idx [64];

    task automatic clear_tr();
        tr_sq0 = '0; tr_sq90 = '0; tr_rx = '0; tr_busy = '0; tr_done = '0;
        for (int i = 0; i < 64; i++) tr_idx[i] = '0;
    endtask

    task automatic sample(input int k);
        tr_sq0[k]  = bus.sq_0deg;
        tr_sq90[k] = bus.sq_90deg;
        tr_rx[k]   = bus.rx_win;
        tr_busy[k] = bus.busy;
        tr_done[k] = bus.done;
        tr_idx[k]  = bus.burst_idx;
    endtask

    task automatic record(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            sample(k);
        end
    endtask

    // Start is presented for one cycle; returns just after the edge E0
    task automatic launch(input int h, input int n, input int l, input int b);
        @(negedge clk);
        bus.cfg_half   = 18'(h);
        bus.cfg_cycles = 8'(n);
        bus.cfg_listen = 20'(l);
        bus.cfg_bursts = 8'(b);
        bus.start      = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        clear_tr();
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((bus.busy || bus.done) && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_chk++;
        if (n >= budget) begin
            n_err++;
            $display("FAIL wait_idle: still busy after %0d cycles, want idle", budget);
        end
        @(negedge clk);
    endtask

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.cfg_half = '0; bus.cfg_cycles = '0; bus.cfg_listen = '0; bus.cfg_bursts = '0;

        repeat (3) @(negedge clk);
        check("reset outputs", 32'(dut_out()), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // A: h=4 N=2 L=3 B=1
        launch(4, 2, 3, 1);
        record(24);
        check("A sq0",  32'(tr_sq0[23:0]),  32'h00F0F0);
        check("A sq90", 32'(tr_sq90[23:0]), 32'h003C3C);
        check("A rx",   32'(tr_rx[23:0]),   32'h070000);
        check("A done", 32'(tr_done[23:0]), 32'h080000);
        check("A busy", 32'(tr_busy[23:0]), 32'h07FFFF);
        wait_idle(50);

        // B: h=5 N=1 L=2 B=3
        launch(5, 1, 2, 3);
        record(40);
        check("B rx cycles",  32'($countones(tr_rx)),   32'd6);
        check("B done count", 32'($countones(tr_done)), 32'd1);
        check("B done at 36", 32'(tr_done[36]), 32'd1);
        check("B sq90 first", 32'(tr_sq90[9:0]), 32'h07C);
        check("B sq0 first",  32'(tr_sq0[9:0]),  32'h3E0);
        check("B idx@12", 32'(tr_idx[12]), 32'd1);
        check("B idx@24", 32'(tr_idx[24]), 32'd2);
        wait_idle(50);

        // C: h=1 and h=0 behave as h=2
        for (int hv = 1; hv >= 0; hv--) begin
            launch(hv, 2, 0, 1);
            record(10);
            check("C sq0",  32'(tr_sq0[9:0]),  32'h0CC);
            check("C done", 32'(tr_done[9:0]), 32'h100);
            wait_idle(50);
        end

        // D: N=0 L=4
        launch(3, 0, 4, 1);
        record(6);
        check("D rx",   32'(tr_rx[5:0]), 32'h0F);
        check("D done", 32'(tr_done[5:0]), 32'h10);
        check("D sq",   32'(tr_sq0[5:0] | tr_sq90[5:0]), 32'h0);
        check("D busy", 32'(tr_busy[5:0]), 32'h0F);
        wait_idle(50);

        // E: N=0 L=0, any B
        launch(3, 0, 0, 3);
        record(3);
        check("E done", 32'(tr_done[2:0]), 32'h1);
        check("E busy", 32'(tr_busy[2:0]), 32'h0);
        wait_idle(50);

        // F: start and cfg_half rewritten mid-burst are ignored
        launch(3, 3, 2, 1);
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            sample(k);
            if (k == 3) begin bus.start = 1'b1; bus.cfg_half = 18'd6; end
            if (k == 4) bus.start = 1'b0;
        end
        check("F sq0",  32'(tr_sq0[23:0]),  32'h038E38);
        check("F done", 32'(tr_done[23:0]), 32'h100000);
        wait_idle(50);

        // G: abort in second TX period, restart one cycle later
        launch(4, 3, 2, 2);
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            sample(k);
            if (k == 9)  bus.abort = 1'b1;
            if (k == 10) begin bus.abort = 1'b0; bus.start = 1'b1; end
            if (k == 11) bus.start = 1'b0;
        end
        check("G busy",   32'(tr_busy[14:0]), 32'h7BFF);
        check("G sq90@10", 32'(tr_sq90[10]), 32'd0);
        check("G done",   32'(tr_done[14:0]), 32'h0);
        wait_idle(200);

        // H: start+abort together in IDLE
        @(negedge clk);
        bus.cfg_cycles = 8'd2; bus.start = 1'b1; bus.abort = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0; bus.abort = 1'b0;
        clear_tr();
        record(4);
        check("H busy", 32'(tr_busy[3:0] | tr_done[3:0]), 32'h0);

        // I: async reset mid-LISTEN
        launch(2, 1, 8, 1);
        record(7);
        check("I rx before rst", 32'(tr_rx[6]), 32'd1);
        #2 rst = 1'b1;
        #1 check("I outputs after rst", 32'(dut_out()), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Randomized soak: config churns every cycle
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            bus.cfg_half   = 18'($urandom_range(0, 6));
            bus.cfg_cycles = 8'($urandom_range(0, 3));
            bus.cfg_listen = 20'($urandom_range(0, 4));
            bus.cfg_bursts = 8'($urandom_range(0, 3));
            bus.start      = ($urandom_range(0, 3) == 0);
            bus.abort      = ($urandom_range(0, 79) == 0);
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        wait_idle(600);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
